// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: one-entry skid-free holding stage between execute and memory,
// with forwarding / load-use detection toward execute, sticky FP flags and a sticky halt.
module ex_mem_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_falu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd_num,
    input  logic              ex_register_write,
    input  logic [1:0]        ex_register_src,
    input  logic              ex_we_cache,
    input  logic              ex_we_memory,
    input  logic              ex_is_word,
    input  logic              ex_is_nop,
    input  logic              ex_halted,
    input  logic [5:0]        ex_fp_flags,

    input  logic              flush,
    input  logic              mem_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_falu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [4:0]        mem_rd_num,
    output logic              mem_register_write,
    output logic              mem_we_cache,
    output logic              mem_we_memory,
    output logic              mem_is_word,
    output logic              mem_halted,
    output logic [1:0]        mem_register_src,

    input  logic [4:0]        fwd_rs_num,
    input  logic [4:0]        fwd_rt_num,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use_stall,

    output logic [5:0]        fp_sticky,
    input  logic              fp_sticky_clear,
    output logic              halted
);

    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_FP  = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] falu_result;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        rd_num;
        logic              register_write;
        logic [1:0]        register_src;
        logic              we_cache;
        logic              we_memory;
        logic              is_word;
        logic              halted;
    } entry_t;

    entry_t      entry_d, entry_q;
    logic        valid_d, valid_q;
    logic [5:0]  sticky_d, sticky_q;
    logic        halted_d, halted_q;
    logic        capture;
    logic        rd_live;

    assign ex_ready = !halted_q && (!valid_q || mem_ready);
    assign capture  = ex_valid && ex_ready && !flush;

    // NOTE: every field of entry_d is assigned on every evaluation, so no latch is inferred.
    always_comb begin
        entry_d.alu_result     = ex_alu_result;
        entry_d.falu_result    = ex_falu_result;
        entry_d.store_data     = ex_store_data;
        entry_d.rd_num         = ex_rd_num;
        entry_d.register_src   = ex_register_src;
        entry_d.is_word        = ex_is_word;
        entry_d.halted         = ex_halted;
        // A nop travels down the pipe but must never write architectural state.
        entry_d.register_write = ex_register_write && !ex_is_nop;
        entry_d.we_cache       = ex_we_cache && !ex_is_nop;
        entry_d.we_memory      = ex_we_memory && !ex_is_nop;
    end

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (capture)
            valid_d = 1'b1;
        else if (mem_ready)
            valid_d = 1'b0;

        sticky_d = fp_sticky_clear ? 6'b0 : sticky_q;
        if (capture && !ex_is_nop)
            sticky_d = sticky_d | ex_fp_flags;

        halted_d = halted_q || (capture && ex_halted);
    end

    // NOTE: the payload is reset too, so every mem_* output reads 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (capture) begin
            // NOTE: sequential state uses non-blocking assignments only.
            entry_q <= entry_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            sticky_q <= 6'b0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            halted_q <= halted_d;
        end
    end

    assign mem_valid          = valid_q;
    assign mem_alu_result     = entry_q.alu_result;
    assign mem_falu_result    = entry_q.falu_result;
    assign mem_store_data     = entry_q.store_data;
    assign mem_rd_num         = entry_q.rd_num;
    assign mem_register_write = entry_q.register_write;
    assign mem_register_src   = entry_q.register_src;
    assign mem_we_cache       = entry_q.we_cache;
    assign mem_we_memory      = entry_q.we_memory;
    assign mem_is_word        = entry_q.is_word;
    assign mem_halted         = entry_q.halted;
    assign fp_sticky          = sticky_q;
    assign halted             = halted_q;

    // A load result is not available yet, so a match against it stalls instead of forwarding.
    assign rd_live        = valid_q && entry_q.register_write && (entry_q.rd_num != 5'd0);
    assign fwd_rs_hit     = rd_live && (entry_q.rd_num == fwd_rs_num) && (entry_q.register_src != SRC_MEM);
    assign fwd_rt_hit     = rd_live && (entry_q.rd_num == fwd_rt_num) && (entry_q.register_src != SRC_MEM);
    assign fwd_data       = (entry_q.register_src == SRC_FP) ? entry_q.falu_result : entry_q.alu_result;
    assign load_use_stall = rd_live && (entry_q.register_src == SRC_MEM) &&
                            ((entry_q.rd_num == fwd_rs_num) || (entry_q.rd_num == fwd_rt_num));

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed sequences, a forwarding vector table
// and a randomized phase scored against a transaction-level model.
module tb_ex_mem_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ex_valid, ex_ready;
    logic [W-1:0] ex_alu_result, ex_falu_result, ex_store_data;
    logic [4:0]   ex_rd_num;
    logic         ex_register_write;
    logic [1:0]   ex_register_src;
    logic         ex_we_cache, ex_we_memory, ex_is_word, ex_is_nop, ex_halted;
    logic [5:0]   ex_fp_flags;
    logic         flush, mem_ready, mem_valid;
    logic [W-1:0] mem_alu_result, mem_falu_result, mem_store_data;
    logic [4:0]   mem_rd_num;
    logic         mem_register_write, mem_we_cache, mem_we_memory, mem_is_word, mem_halted;
    logic [1:0]   mem_register_src;
    logic [4:0]   fwd_rs_num, fwd_rt_num;
    logic         fwd_rs_hit, fwd_rt_hit;
    logic [W-1:0] fwd_data;
    logic         load_use_stall;
    logic [5:0]   fp_sticky;
    logic         fp_sticky_clear;
    logic         halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_falu_result(ex_falu_result), .ex_store_data(ex_store_data),
        .ex_rd_num(ex_rd_num), .ex_register_write(ex_register_write), .ex_register_src(ex_register_src),
        .ex_we_cache(ex_we_cache), .ex_we_memory(ex_we_memory), .ex_is_word(ex_is_word),
        .ex_is_nop(ex_is_nop), .ex_halted(ex_halted), .ex_fp_flags(ex_fp_flags),
        .flush(flush), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_falu_result(mem_falu_result), .mem_store_data(mem_store_data),
        .mem_rd_num(mem_rd_num), .mem_register_write(mem_register_write), .mem_we_cache(mem_we_cache),
        .mem_we_memory(mem_we_memory), .mem_is_word(mem_is_word), .mem_halted(mem_halted),
        .mem_register_src(mem_register_src),
        .fwd_rs_num(fwd_rs_num), .fwd_rt_num(fwd_rt_num), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
        .fwd_data(fwd_data), .load_use_stall(load_use_stall),
        .fp_sticky(fp_sticky), .fp_sticky_clear(fp_sticky_clear), .halted(halted)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        ex_valid = 0; ex_alu_result = '0; ex_falu_result = '0; ex_store_data = '0;
        ex_rd_num = 0; ex_register_write = 0; ex_register_src = 0; ex_we_cache = 0;
        ex_we_memory = 0; ex_is_word = 0; ex_is_nop = 0; ex_halted = 0; ex_fp_flags = 0;
        flush = 0; fp_sticky_clear = 0; fwd_rs_num = 0; fwd_rt_num = 0;
    endtask

    task automatic put(input logic [W-1:0] alu, input logic [4:0] rd, input logic [1:0] src,
                       input logic [5:0] flags);
        ex_valid = 1; ex_alu_result = alu; ex_falu_result = alu ^ 32'hFFFF_0000;
        ex_store_data = ~alu; ex_rd_num = rd; ex_register_write = 1; ex_register_src = src;
        ex_fp_flags = flags; ex_is_nop = 0; ex_halted = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] rd;
        logic       rw;
        logic [1:0] src;
        logic       nop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exp_rs;
        logic       exp_rt;
        logic       exp_stall;
        logic       exp_falu;
    } fwd_vec_t;

    typedef struct {
        logic [W-1:0] alu, falu, sd;
        logic [4:0]   rd;
        logic         rw;
        logic [1:0]   src;
        logic         wc, wm, word, halt;
    } ent_t;

    fwd_vec_t tbl[10];
    ent_t     m_ent;
    bit       m_valid, m_halted, m_ready, m_take, e_rs, e_rt, e_stall;
    logic [5:0] m_sticky;

    initial begin
        tbl[0] = '{5'd9,  1, 2'b00, 0, 5'd9,  5'd0,  1, 0, 0, 0};
        tbl[1] = '{5'd9,  1, 2'b01, 0, 5'd9,  5'd0,  0, 0, 1, 0};
        tbl[2] = '{5'd0,  1, 2'b00, 0, 5'd0,  5'd0,  0, 0, 0, 0};
        tbl[3] = '{5'd0,  1, 2'b01, 0, 5'd0,  5'd0,  0, 0, 0, 0};
        tbl[4] = '{5'd7,  1, 2'b10, 0, 5'd1,  5'd7,  0, 1, 0, 1};
        tbl[5] = '{5'd7,  1, 2'b11, 0, 5'd7,  5'd7,  1, 1, 0, 0};
        tbl[6] = '{5'd7,  0, 2'b00, 0, 5'd7,  5'd7,  0, 0, 0, 0};
        tbl[7] = '{5'd7,  1, 2'b00, 1, 5'd7,  5'd7,  0, 0, 0, 0};
        tbl[8] = '{5'd12, 1, 2'b01, 0, 5'd3,  5'd12, 0, 0, 1, 0};
        tbl[9] = '{5'd31, 1, 2'b00, 0, 5'd30, 5'd30, 0, 0, 0, 0};

        rst_n = 0; clr_in(); mem_ready = 0;
        #12;
        check("reset mem_valid", mem_valid, 0);
        check("reset halted", halted, 0);
        check("reset fp_sticky", fp_sticky, 0);
        check("reset mem_alu", mem_alu_result, 0);
        check("reset ex_ready", ex_ready, 1);

        // Capture then hold, first edge after reset release.
        @(negedge clk);
        rst_n = 1;
        put(32'h5, 5'd8, 2'b00, 6'b0);
        cyc();
        clr_in();
        check("hold valid", mem_valid, 1);
        check("hold alu", mem_alu_result, 32'h5);
        check("hold rd", mem_rd_num, 8);
        check("hold ex_ready", ex_ready, 0);
        for (int i = 0; i < 3; i++) begin
            put(32'h77, 5'd2, 2'b00, 6'b0);
            cyc();
            check("stall valid", mem_valid, 1);
            check("stall alu", mem_alu_result, 32'h5);
            check("stall rd", mem_rd_num, 8);
        end
        clr_in(); mem_ready = 1;
        cyc();
        check("drain valid", mem_valid, 0);

        // Back-to-back captures without a bubble.
        put(32'hA, 5'd3, 2'b00, 6'b0);
        cyc();
        check("b2b A valid", mem_valid, 1);
        check("b2b A rd", mem_rd_num, 3);
        put(32'hB, 5'd4, 2'b00, 6'b0);
        cyc();
        check("b2b B valid", mem_valid, 1);
        check("b2b B rd", mem_rd_num, 4);
        check("b2b B alu", mem_alu_result, 32'hB);
        clr_in();
        cyc();
        check("b2b drained", mem_valid, 0);

        // Flush beats a simultaneous capture and keeps the sticky flags.
        mem_ready = 0;
        put(32'h55, 5'd5, 2'b00, 6'b000010);
        cyc();
        check("flush pre valid", mem_valid, 1);
        check("flush pre sticky", fp_sticky, 6'b000010);
        put(32'h66, 5'd6, 2'b00, 6'b010000);
        flush = 1; mem_ready = 1;
        cyc();
        clr_in();
        check("flush valid", mem_valid, 0);
        check("flush sticky", fp_sticky, 6'b000010);

        // Sticky FP flag accumulation, clear-with-capture and nop masking.
        fp_sticky_clear = 1;
        cyc();
        clr_in();
        check("sticky cleared", fp_sticky, 0);
        put(32'h1, 5'd1, 2'b00, 6'b000001);
        cyc();
        check("sticky 1", fp_sticky, 6'b000001);
        put(32'h2, 5'd1, 2'b00, 6'b100000);
        cyc();
        check("sticky or", fp_sticky, 6'b100001);
        put(32'h3, 5'd1, 2'b00, 6'b000100);
        fp_sticky_clear = 1;
        cyc();
        check("sticky clear+cap", fp_sticky, 6'b000100);
        clr_in();
        put(32'h4, 5'd6, 2'b00, 6'b111111);
        ex_is_nop = 1; ex_we_cache = 1; ex_we_memory = 1;
        cyc();
        clr_in();
        check("nop sticky", fp_sticky, 6'b000100);
        check("nop valid", mem_valid, 1);
        check("nop regwrite", mem_register_write, 0);
        check("nop we_cache", mem_we_cache, 0);
        check("nop we_memory", mem_we_memory, 0);

        // Forwarding / load-use vector table.
        for (int i = 0; i < 10; i++) begin
            clr_in(); mem_ready = 1;
            ex_valid = 1; ex_rd_num = tbl[i].rd; ex_register_write = tbl[i].rw;
            ex_register_src = tbl[i].src; ex_is_nop = tbl[i].nop;
            ex_alu_result = 32'h100 + i; ex_falu_result = 32'h200 + i;
            cyc();
            clr_in(); mem_ready = 0;
            fwd_rs_num = tbl[i].rs; fwd_rt_num = tbl[i].rt;
            #1;
            check($sformatf("vec%0d valid", i), mem_valid, 1);
            check($sformatf("vec%0d rs_hit", i), fwd_rs_hit, tbl[i].exp_rs);
            check($sformatf("vec%0d rt_hit", i), fwd_rt_hit, tbl[i].exp_rt);
            check($sformatf("vec%0d stall", i), load_use_stall, tbl[i].exp_stall);
            if (tbl[i].exp_rs || tbl[i].exp_rt)
                check($sformatf("vec%0d data", i), fwd_data, tbl[i].exp_falu ? 32'h200 + i : 32'h100 + i);
        end

        // Randomized phase from a known empty, flag-free state.
        clr_in(); flush = 1;
        cyc();
        clr_in(); fp_sticky_clear = 1;
        cyc();
        m_valid = 0; m_sticky = 0; m_halted = 0;
        for (int n = 0; n < 400; n++) begin
            clr_in();
            ex_valid          = ($urandom_range(0, 3) != 0);
            ex_alu_result     = $urandom;
            ex_falu_result    = $urandom;
            ex_store_data     = $urandom;
            ex_rd_num         = 5'($urandom_range(0, 7));
            ex_register_write = 1'($urandom_range(0, 1));
            ex_register_src   = 2'($urandom_range(0, 3));
            ex_we_cache       = 1'($urandom_range(0, 1));
            ex_we_memory      = 1'($urandom_range(0, 1));
            ex_is_word        = 1'($urandom_range(0, 1));
            ex_is_nop         = ($urandom_range(0, 7) == 0);
            ex_fp_flags       = 6'(1 << $urandom_range(0, 5));
            flush             = ($urandom_range(0, 15) == 0);
            fp_sticky_clear   = !flush && ($urandom_range(0, 15) == 0);
            mem_ready         = 1'($urandom_range(0, 1));
            fwd_rs_num        = 5'($urandom_range(0, 7));
            fwd_rt_num        = 5'($urandom_range(0, 7));
            #1;
            m_ready = !m_halted && (!m_valid || mem_ready);
            e_rs    = m_valid && m_ent.rw && m_ent.rd != 0 && m_ent.rd == fwd_rs_num && m_ent.src != 2'b01;
            e_rt    = m_valid && m_ent.rw && m_ent.rd != 0 && m_ent.rd == fwd_rt_num && m_ent.src != 2'b01;
            e_stall = m_valid && m_ent.rw && m_ent.rd != 0 && m_ent.src == 2'b01 &&
                      (m_ent.rd == fwd_rs_num || m_ent.rd == fwd_rt_num);
            check("rnd ex_ready", ex_ready, m_ready);
            check("rnd rs_hit", fwd_rs_hit, e_rs);
            check("rnd rt_hit", fwd_rt_hit, e_rt);
            check("rnd stall", load_use_stall, e_stall);
            if (e_rs || e_rt)
                check("rnd fwd_data", fwd_data, (m_ent.src == 2'b10) ? m_ent.falu : m_ent.alu);

            m_take = ex_valid && m_ready && !flush;
            if (m_take)
                m_ent = '{ex_alu_result, ex_falu_result, ex_store_data, ex_rd_num,
                          ex_register_write && !ex_is_nop, ex_register_src,
                          ex_we_cache && !ex_is_nop, ex_we_memory && !ex_is_nop, ex_is_word, ex_halted};
            if (flush)          m_valid = 0;
            else if (m_take)    m_valid = 1;
            else if (mem_ready) m_valid = 0;
            if (fp_sticky_clear) m_sticky = 0;
            if (m_take && !ex_is_nop) m_sticky = m_sticky | ex_fp_flags;

            cyc();
            check("rnd valid", mem_valid, m_valid);
            check("rnd sticky", fp_sticky, m_sticky);
            check("rnd halted", halted, m_halted);
            if (m_valid) begin
                check("rnd alu", mem_alu_result, m_ent.alu);
                check("rnd falu", mem_falu_result, m_ent.falu);
                check("rnd sd", mem_store_data, m_ent.sd);
                check("rnd rd", mem_rd_num, m_ent.rd);
                check("rnd rw", mem_register_write, m_ent.rw);
                check("rnd src", mem_register_src, m_ent.src);
                check("rnd wc", mem_we_cache, m_ent.wc);
                check("rnd wm", mem_we_memory, m_ent.wm);
                check("rnd word", mem_is_word, m_ent.word);
            end
        end

        // Halt: sticky, blocks captures, held entry drains; then asynchronous reset.
        clr_in(); flush = 1;
        cyc();
        clr_in(); fp_sticky_clear = 1;
        cyc();
        clr_in(); mem_ready = 0;
        put(32'h99, 5'd10, 2'b00, 6'b001000);
        ex_halted = 1;
        cyc();
        clr_in();
        check("halt set", halted, 1);
        check("halt mem_halted", mem_halted, 1);
        check("halt valid", mem_valid, 1);
        check("halt sticky", fp_sticky, 6'b001000);
        check("halt ex_ready", ex_ready, 0);
        mem_ready = 1;
        put(32'hAA, 5'd11, 2'b00, 6'b0);
        cyc();
        clr_in();
        check("halt drained", mem_valid, 0);
        check("halt stays", halted, 1);
        check("halt ready after drain", ex_ready, 0);
        #3;
        rst_n = 0;
        #1;
        check("async rst valid", mem_valid, 0);
        check("async rst halted", halted, 0);
        check("async rst sticky", fp_sticky, 0);
        check("async rst ready", ex_ready, 1);

        @(negedge clk);
        rst_n = 1;
        mem_ready = 0;
        put(32'h1234, 5'd9, 2'b00, 6'b000001);
        cyc();
        clr_in();
        check("post rst capture", mem_valid, 1);
        check("post rst alu", mem_alu_result, 32'h1234);
        fwd_rs_num = 9;
        #1;
        check("post rst fwd hit", fwd_rs_hit, 1);
        #2;
        rst_n = 0;
        #1;
        check("mid rst valid", mem_valid, 0);
        check("mid rst alu", mem_alu_result, 0);
        check("mid rst rd", mem_rd_num, 0);
        check("mid rst fwd hit", fwd_rs_hit, 0);
        check("mid rst stall", load_use_stall, 0);
        #10;
        rst_n = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
